// File: rtl/conv_kernel_scheduler.sv
// Assembles a stream of weight words into ping-pong 3x3+bias banks and presents one set per swap.
// Optional macro CONV_SCHED_ERR_EN adds the sticky err_underrun flag.
module conv_kernel_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    ch_in,
  input  logic [CNT_WIDTH-1:0]    num_blocks,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  input  logic                    swap,
  output logic                    k_valid,
  output logic [9*DATA_WIDTH-1:0] k_out,
  output logic [DATA_WIDTH-1:0]   bias,
  output logic [CNT_WIDTH-1:0]    cur_ch,
  output logic                    busy,
  output logic                    done
`ifdef CONV_SCHED_ERR_EN
  ,
  output logic                    err_underrun
`endif
);
  localparam int unsigned NUM_WORDS = 10;
  localparam int unsigned NUM_TAPS  = 9;
  localparam int unsigned IDX_W     = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0]   r_back [NUM_WORDS];
  logic [DATA_WIDTH-1:0]   w_back_nxt [NUM_WORDS];
  logic                    r_back_full, w_back_full_nxt;
  logic                    r_pending, w_pending_nxt;
  logic [CNT_WIDTH-1:0]    r_ch_in, w_ch_in_nxt;
  logic [CNT_WIDTH-1:0]    r_nblk, w_nblk_nxt;
  logic [CNT_WIDTH-1:0]    r_total, w_total_nxt;
  logic [CNT_WIDTH-1:0]    r_blk, w_blk_nxt;
  logic [CNT_WIDTH-1:0]    r_loaded, w_loaded_nxt;
  logic [CNT_WIDTH-1:0]    r_cur_ch, w_cur_ch_nxt;
  logic [9*DATA_WIDTH-1:0] r_k_out, w_k_out_nxt;
  logic [DATA_WIDTH-1:0]   r_bias, w_bias_nxt;
  logic                    r_k_valid, w_k_valid_nxt;
  logic                    r_s_ready, w_s_ready_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_service;
  logic                    w_beat;
  logic                    w_last;

  assign w_beat = s_valid & r_s_ready;
  assign w_last = (r_cur_ch == r_ch_in - CNT_WIDTH'(1)) && (r_blk == r_nblk - CNT_WIDTH'(1));

  // Next-state, bank and counter updates; registered outputs are derived from the next state.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_back_nxt      = r_back;
    w_back_full_nxt = r_back_full;
    w_pending_nxt   = r_pending;
    w_ch_in_nxt     = r_ch_in;
    w_nblk_nxt      = r_nblk;
    w_total_nxt     = r_total;
    w_blk_nxt       = r_blk;
    w_loaded_nxt    = r_loaded;
    w_cur_ch_nxt    = r_cur_ch;
    w_k_out_nxt     = r_k_out;
    w_bias_nxt      = r_bias;
    w_k_valid_nxt   = r_k_valid;
    w_done_nxt      = 1'b0;
    w_service       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_ch_in_nxt     = ch_in;
          w_nblk_nxt      = num_blocks;
          w_total_nxt     = CNT_WIDTH'(ch_in * num_blocks);
          w_idx_nxt       = '0;
          w_blk_nxt       = '0;
          w_loaded_nxt    = '0;
          w_cur_ch_nxt    = '0;
          w_pending_nxt   = 1'b0;
          w_back_full_nxt = 1'b0;
          if (ch_in == '0 || num_blocks == '0) w_done_nxt = 1'b1;
          else w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_beat) begin
          for (int i = 0; i < NUM_TAPS; i++)
            if (r_idx == IDX_W'(i)) w_k_out_nxt[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
          if (r_idx == LAST_IDX) begin
            w_bias_nxt    = s_data;
            w_idx_nxt     = '0;
            w_loaded_nxt  = r_loaded + CNT_WIDTH'(1);
            w_k_valid_nxt = 1'b1;
            w_state_nxt   = S_RUN;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_RUN: begin
        if (w_beat) begin
          w_back_nxt[r_idx] = s_data;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt       = '0;
            w_back_full_nxt = 1'b1;
            w_loaded_nxt    = r_loaded + CNT_WIDTH'(1);
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        // A pending swap only sees the back bank full one cycle after its last beat.
        if (r_pending && r_back_full) begin
          w_service = 1'b1;
        end else if (swap && r_k_valid) begin
          if (w_last) begin
            w_state_nxt   = S_DONE;
            w_done_nxt    = 1'b1;
            w_k_valid_nxt = 1'b0;
          end else if (r_back_full) begin
            w_service = 1'b1;
          end else begin
            w_pending_nxt = 1'b1;
            w_k_valid_nxt = 1'b0;
          end
        end
        if (w_service) begin
          for (int i = 0; i < NUM_TAPS; i++)
            w_k_out_nxt[i*DATA_WIDTH +: DATA_WIDTH] = r_back[i];
          w_bias_nxt      = r_back[NUM_WORDS-1];
          w_back_full_nxt = 1'b0;
          w_pending_nxt   = 1'b0;
          w_k_valid_nxt   = 1'b1;
          if (r_cur_ch == r_ch_in - CNT_WIDTH'(1)) begin
            w_cur_ch_nxt = '0;
            w_blk_nxt    = r_blk + CNT_WIDTH'(1);
          end else begin
            w_cur_ch_nxt = r_cur_ch + CNT_WIDTH'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt    = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
    w_s_ready_nxt = (w_state_nxt == S_LOAD) ||
                    ((w_state_nxt == S_RUN) && !w_back_full_nxt && (w_loaded_nxt < w_total_nxt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      for (int i = 0; i < NUM_WORDS; i++) r_back[i] <= '0;
      r_back_full <= 1'b0;
      r_pending   <= 1'b0;
      r_ch_in     <= '0;
      r_nblk      <= '0;
      r_total     <= '0;
      r_blk       <= '0;
      r_loaded    <= '0;
      r_cur_ch    <= '0;
      r_k_out     <= '0;
      r_bias      <= '0;
      r_k_valid   <= 1'b0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_back      <= w_back_nxt;
      r_back_full <= w_back_full_nxt;
      r_pending   <= w_pending_nxt;
      r_ch_in     <= w_ch_in_nxt;
      r_nblk      <= w_nblk_nxt;
      r_total     <= w_total_nxt;
      r_blk       <= w_blk_nxt;
      r_loaded    <= w_loaded_nxt;
      r_cur_ch    <= w_cur_ch_nxt;
      r_k_out     <= w_k_out_nxt;
      r_bias      <= w_bias_nxt;
      r_k_valid   <= w_k_valid_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

`ifdef CONV_SCHED_ERR_EN
  logic r_err;

  // Sticky: set whenever a held swap is finally serviced.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (r_state == S_RUN && r_pending && r_back_full) r_err <= 1'b1;
  end

  assign err_underrun = r_err;
`endif

  assign s_ready = r_s_ready;
  assign k_valid = r_k_valid;
  assign k_out   = r_k_out;
  assign bias    = r_bias;
  assign cur_ch  = r_cur_ch;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Self-checking bench for conv_kernel_scheduler: table of runs plus hand-written stall/reset sequences.
module tb_conv_kernel_scheduler;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;

  logic          clk, rst, start, s_valid, s_ready, swap, k_valid, busy, done;
  logic [CW-1:0] ch_in, num_blocks, cur_ch;
  logic [DW-1:0] s_data, bias;
  logic [9*DW-1:0] k_out;
`ifdef CONV_SCHED_ERR_EN
  logic          err_underrun;
`endif

  typedef struct {
    logic [9*DW-1:0] k;
    logic [DW-1:0]   b;
    logic [CW-1:0]   ch;
  } exp_t;

  typedef struct {
    int ch;
    int nb;
    int gap;
    int restart_at;
    int exp_beats;
    int exp_sets;
  } vec_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   beats     = 0;
  int   word      = 1;
  int   sets_seen = 0;
  logic kv_prev   = 1'b0;
  logic sw_prev   = 1'b0;

  conv_kernel_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ch_in        (ch_in),
    .num_blocks   (num_blocks),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .swap         (swap),
    .k_valid      (k_valid),
    .k_out        (k_out),
    .bias         (bias),
    .cur_ch       (cur_ch),
    .busy         (busy),
    .done         (done)
`ifdef CONV_SCHED_ERR_EN
    ,
    .err_underrun (err_underrun)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_w(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk_exp(input int j, input int ch);
    exp_t e;
    for (int i = 0; i < 9; i++) e.k[i*DW +: DW] = DW'(10*j + i + 1);
    e.b  = DW'(10*j + 10);
    e.ch = CW'(j % ch);
    return e;
  endfunction

  // Weight source: counting words 1,2,3,... advancing on every accepted beat.
  initial begin
    forever begin
      @(posedge clk);
      if (s_valid && s_ready && !rst) begin
        beats++;
        word++;
        #1 s_data = DW'(word);
      end
    end
  end

  // Scoreboard sink: every newly presented set is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (k_valid && (!kv_prev || sw_prev)) begin
        sets_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL set_unexpected: got bias %0d ch %0d expected no set", bias, cur_ch);
        end else begin
          e = exp_q.pop_front();
          chk_w("set_k_out", 160'(k_out), 160'(e.k));
          chk("set_bias", int'(bias), int'(e.b));
          chk("set_cur_ch", int'(cur_ch), int'(e.ch));
        end
      end
      kv_prev = k_valid;
      sw_prev = swap & k_valid;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_k_valid"}, int'(k_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cur_ch"}, int'(cur_ch), 0);
    chk({tag, "_bias"}, int'(bias), 0);
    chk_w({tag, "_k_out"}, 160'(k_out), 160'(0));
`ifdef CONV_SCHED_ERR_EN
    chk({tag, "_err"}, int'(err_underrun), 0);
`endif
  endtask

  task automatic pulse_reset();
    rst = 1'b1; start = 1'b0; swap = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("rst");
  endtask

  task automatic begin_run(input int ch, input int nb);
    word = 1; s_data = DW'(1); beats = 0; sets_seen = 0;
    for (int j = 0; j < ch*nb; j++) exp_q.push_back(mk_exp(j, ch));
    ch_in = CW'(ch); num_blocks = CW'(nb); start = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_run(input vec_t v, input int abort_at, output int ndone);
    int   since, nsw, total;
    logic seen;
    since = 0; nsw = 0; ndone = 0; seen = 1'b0;
    total = v.ch * v.nb;
    begin_run(v.ch, v.nb);
    chk("start_s_ready", int'(s_ready), (total != 0) ? 1 : 0);
    chk("start_busy", int'(busy), (total != 0) ? 1 : 0);
    chk("start_done", int'(done), (total == 0) ? 1 : 0);
    if (done) ndone++;
    if (total == 0) begin
      repeat (20) begin
        @(posedge clk); #1;
        if (s_ready || busy || k_valid || done) seen = 1'b1;
      end
      chk("zero_quiet", int'(seen), 0);
      s_valid = 1'b0;
      return;
    end
    for (int c = 0; c < 4000 && ndone == 0; c++) begin
      @(posedge clk); #1;
      swap = 1'b0; start = 1'b0; ch_in = CW'(v.ch);
      if (done) ndone++;
      else if (k_valid) begin
        since++;
        if (nsw == abort_at && since == 5) begin
          rst = 1'b1; s_valid = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          check_zero("abort");
          exp_q.delete();
          return;
        end
        if (nsw == v.restart_at && since == 3) begin
          start = 1'b1;
          ch_in = CW'(v.ch + 3);
        end
        if (since >= v.gap) begin
          swap = 1'b1; since = 0; nsw++;
        end
      end
    end
    @(posedge clk); #1;
    chk("post_done", int'(done), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_k_valid", int'(k_valid), 0);
    s_valid = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    int   nd;
    rst = 1'b1; start = 1'b0; swap = 1'b0; s_valid = 1'b0; s_data = DW'(1);
    ch_in = '0; num_blocks = '0;

    // {ch_in, num_blocks, swap gap, restart-at-swap, expected beats, expected sets}
    vt[0] = '{3, 2, 12, -1, 60, 6};
    vt[1] = '{1, 1, 12, -1, 10, 1};
    vt[2] = '{2, 3, 15, -1, 60, 6};
    vt[3] = '{0, 5, 12, -1,  0, 0};
    vt[4] = '{4, 0, 12, -1,  0, 0};
    vt[5] = '{2, 2, 12,  1, 40, 4};

    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      do_run(vt[i], -1, nd);
      chk($sformatf("v%0d_beats", i), beats, vt[i].exp_beats);
      chk($sformatf("v%0d_sets", i), sets_seen, vt[i].exp_sets);
      chk($sformatf("v%0d_done_pulses", i), nd, 1);
      chk($sformatf("v%0d_queue_left", i), exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
    end
`ifdef CONV_SCHED_ERR_EN
    chk("table_err_clean", int'(err_underrun), 0);
`endif

    // Back-pressure: stall with the back bank half full, then swap.
    begin_run(2, 1);
    for (int c = 0; c < 200 && beats < 15; c++) begin @(posedge clk); #1; end
    s_valid = 1'b0;
    chk("bp_k_valid_pre", int'(k_valid), 1);
    swap = 1'b1;
    @(posedge clk); #1;
    swap = 1'b0;
    chk("bp_k_valid_drop", int'(k_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_k_valid_held", int'(k_valid), 0);
    chk("bp_beats_stalled", beats, 15);
    s_valid = 1'b1;
    for (int c = 0; c < 200 && beats < 20; c++) begin @(posedge clk); #1; end
    chk("bp_k_valid_at_fill", int'(k_valid), 0);
    @(posedge clk); #1;
    chk("bp_k_valid_after", int'(k_valid), 1);
    chk("bp_cur_ch", int'(cur_ch), 1);
`ifdef CONV_SCHED_ERR_EN
    chk("bp_err", int'(err_underrun), 1);
`endif
    swap = 1'b1;
    @(posedge clk); #1;
    swap = 1'b0;
    chk("bp_done", int'(done), 1);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_queue_left", exp_q.size(), 0);

    // Same-edge swap: swap sampled together with the 10th back beat.
    pulse_reset();
    begin_run(2, 1);
    for (int c = 0; c < 200 && beats < 19; c++) begin @(posedge clk); #1; end
    chk("se_k_valid_pre", int'(k_valid), 1);
    chk("se_s_ready_pre", int'(s_ready), 1);
    swap = 1'b1;
    @(posedge clk); #1;
    swap = 1'b0;
    chk("se_beats", beats, 20);
    chk("se_k_valid_n1", int'(k_valid), 0);
    @(posedge clk); #1;
    chk("se_k_valid_n2", int'(k_valid), 1);
    chk("se_cur_ch", int'(cur_ch), 1);
`ifdef CONV_SCHED_ERR_EN
    chk("se_err", int'(err_underrun), 1);
`endif
    swap = 1'b1;
    @(posedge clk); #1;
    swap = 1'b0;
    chk("se_done", int'(done), 1);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("se_queue_left", exp_q.size(), 0);

    // Reset during set 4 of 6, then a clean rerun of the basic case.
    pulse_reset();
    do_run(vt[0], 3, nd);
    repeat (2) @(posedge clk);
    #1;
    do_run(vt[0], -1, nd);
    chk("rerun_beats", beats, 60);
    chk("rerun_sets", sets_seen, 6);
    chk("rerun_done_pulses", nd, 1);
    chk("rerun_queue_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
